// File: rtl/parse_stream.sv
// Streaming Kyber Parse: splits XOF byte triplets into 12-bit candidates, keeps those below Q
// and emits N_COEFFS coefficients in OUT_LANES-wide beats. Define PARSE_REJCNT_EN to add o_rej_cnt.
module parse_stream #(
    parameter int unsigned IN_BYTES  = 24,
    parameter int unsigned OUT_LANES = 4,
    parameter int unsigned BUF_DEPTH = 32,
    parameter int unsigned N_COEFFS  = 256,
    parameter int unsigned Q         = 3329
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [IN_BYTES*8-1:0]   i_ibytes,
    input  logic                    i_ibytes_valid,
    output logic                    o_ibytes_ready,
    output logic [OUT_LANES*12-1:0] o_coeffs,
    output logic                    o_coeffs_valid,
    input  logic                    i_coeffs_ready,
    output logic                    o_done,
    output logic                    o_busy
`ifdef PARSE_REJCNT_EN
    ,
    output logic [15:0]             o_rej_cnt
`endif
);
    localparam int unsigned CPB   = 2 * IN_BYTES / 3;
    localparam int unsigned NTRIP = IN_BYTES / 3;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(N_COEFFS + 1);
    localparam int unsigned IDX_W = $clog2(CPB + 1);
    localparam int unsigned CMP_N = 1 << IDX_W;

    generate
        if (BUF_DEPTH < CPB + OUT_LANES || IN_BYTES % 3 != 0) begin : g_bad_cfg
            $error("parse_stream: BUF_DEPTH too small or IN_BYTES not a multiple of 3");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;
    state_t state, nstate;

    logic [11:0]      cand   [CPB];
    logic [11:0]      comp   [CMP_N];
    logic [11:0]      cbuf_q [BUF_DEPTH];
    logic [11:0]      cbuf_d [BUF_DEPTH];
    logic [IDX_W-1:0] n_acc;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_acc_q, cnt_acc_d, cnt_out_q, cnt_out_d;
    int unsigned      keep;
    logic             push, pop;
    logic             ready_d, valid_d, done_d, busy_d;
    logic [OUT_LANES*12-1:0] coeffs_d;

    assign push = i_ibytes_valid && o_ibytes_ready;
    assign pop  = o_coeffs_valid && i_coeffs_ready;

    // Two 12-bit candidates per byte triplet, d1 first.
    always_comb begin
        for (int unsigned k = 0; k < CPB; k++) cand[k] = '0;
        for (int unsigned j = 0; j < NTRIP; j++) begin
            cand[2*j]   = {i_ibytes[24*j+8 +: 4], i_ibytes[24*j +: 8]};
            cand[2*j+1] = {i_ibytes[24*j+16 +: 8], i_ibytes[24*j+12 +: 4]};
        end
    end

    // In-order compaction of accepted candidates; anything past N_COEFFS is dropped.
`ifdef PARSE_REJCNT_EN
    logic [IDX_W-1:0] n_rej;
`endif
    always_comb begin
        n_acc = '0;
`ifdef PARSE_REJCNT_EN
        n_rej = '0;
`endif
        for (int unsigned k = 0; k < CMP_N; k++) comp[k] = '0;
        for (int unsigned k = 0; k < CPB; k++) begin
            if (32'(cnt_acc_q) + 32'(n_acc) < N_COEFFS) begin
                if (32'(cand[k]) < Q) begin
                    comp[n_acc] = cand[k];
                    n_acc       = n_acc + 1'b1;
                end
`ifdef PARSE_REJCNT_EN
                else begin
                    n_rej = n_rej + 1'b1;
                end
`endif
            end
        end
    end

    // Buffer update: survivors shift down by the popped beat, new entries append behind them.
    always_comb begin
        keep = 32'(occ_q) - (pop ? OUT_LANES : 32'd0);
        for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            cbuf_d[i] = '0;
            if (i < keep)
                cbuf_d[i] = pop ? cbuf_q[(i + OUT_LANES) % BUF_DEPTH] : cbuf_q[i];
            else if (push && (i - keep) < 32'(n_acc))
                cbuf_d[i] = comp[IDX_W'(i - keep)];
        end
        occ_d     = OCC_W'(keep + (push ? 32'(n_acc) : 32'd0));
        cnt_acc_d = cnt_acc_q + (push ? CNT_W'(n_acc) : CNT_W'(0));
        cnt_out_d = cnt_out_q + (pop ? CNT_W'(OUT_LANES) : CNT_W'(0));
        if (state == S_IDLE) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) cbuf_d[i] = '0;
            occ_d     = '0;
            cnt_acc_d = '0;
            cnt_out_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  if (i_start) nstate = S_FILL;
            S_FILL:  if (pop && cnt_out_d == CNT_W'(N_COEFFS)) nstate = S_DONE;
            S_DONE:  nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle state and occupancy.
    always_comb begin
        ready_d  = (nstate == S_FILL) && (32'(cnt_acc_d) < N_COEFFS) &&
                   (BUF_DEPTH - 32'(occ_d) >= CPB);
        valid_d  = (nstate == S_FILL) && (32'(occ_d) >= OUT_LANES);
        done_d   = (nstate == S_DONE);
        busy_d   = (nstate == S_FILL);
        coeffs_d = '0;
        for (int unsigned l = 0; l < OUT_LANES; l++) coeffs_d[12*l +: 12] = cbuf_d[l];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) cbuf_q[i] <= '0;
            occ_q          <= '0;
            cnt_acc_q      <= '0;
            cnt_out_q      <= '0;
            o_ibytes_ready <= 1'b0;
            o_coeffs_valid <= 1'b0;
            o_coeffs       <= '0;
            o_done         <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) cbuf_q[i] <= cbuf_d[i];
            occ_q          <= occ_d;
            cnt_acc_q      <= cnt_acc_d;
            cnt_out_q      <= cnt_out_d;
            o_ibytes_ready <= ready_d;
            o_coeffs_valid <= valid_d;
            o_coeffs       <= coeffs_d;
            o_done         <= done_d;
            o_busy         <= busy_d;
        end
    end

`ifdef PARSE_REJCNT_EN
    // Saturating reject counter; holds after done, cleared when a new polynomial starts.
    logic [16:0] rej_sum;
    assign rej_sum = 17'(o_rej_cnt) + 17'(n_rej);
    always_ff @(posedge i_clk) begin
        if (i_rst)                           o_rej_cnt <= '0;
        else if (state == S_IDLE && i_start) o_rej_cnt <= '0;
        else if (push)                       o_rej_cnt <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_parse_stream.sv
// Randomized bench for parse_stream against a byte-level Parse model; builds with or
// without PARSE_REJCNT_EN.
module tb_parse_stream;
    localparam int IN_BYTES = 24;
    localparam int LANES    = 4;
    localparam int N        = 256;
    localparam int QM       = 3329;
    localparam int IBW      = IN_BYTES * 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IBW-1:0]   ibytes = '0;
    logic             ivalid = 1'b0;
    logic             iready;
    logic [LANES*12-1:0] coeffs;
    logic             cvalid;
    logic             cready = 1'b0;
    logic             done;
    logic             busy;
`ifdef PARSE_REJCNT_EN
    logic [15:0]      rej_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parse_stream dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_ibytes       (ibytes),
        .i_ibytes_valid (ivalid),
        .o_ibytes_ready (iready),
        .o_coeffs       (coeffs),
        .o_coeffs_valid (cvalid),
        .i_coeffs_ready (cready),
        .o_done         (done),
        .o_busy         (busy)
`ifdef PARSE_REJCNT_EN
        ,
        .o_rej_cnt      (rej_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IBW-1:0] make_beat(input int mode);
        logic [7:0] b;
        make_beat = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            case (mode)
                0:       b = 8'h00;
                2:       b = 8'hFF;
                3:       b = (k % 3 == 0) ? 8'h00 : ((k % 3 == 1) ? 8'h1D : 8'hD0);
                default: b = 8'($urandom);
            endcase
            make_beat[8*k +: 8] = b;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(iready), 64'd0);
        check({tag, "_valid"},  64'(cvalid), 64'd0);
        check({tag, "_coeffs"}, 64'(coeffs), 64'd0);
        check({tag, "_done"},   64'(done),   64'd0);
        check({tag, "_busy"},   64'(busy),   64'd0);
    endtask

    // One polynomial: mode picks the byte pattern; stall holds output ready low for that many
    // cycles; max_beats caps input beats (<0 none); abort_cyc applies reset; restart_cyc pulses i_start.
    task automatic run_poly(input int mode, input int rdy_pct, input int stall,
                            input int max_beats, input int abort_cyc, input int restart_cyc);
        logic [IBW-1:0]      beat;
        logic [LANES*12-1:0] expv;
        int  exp_q[$];
        int  dd[2];
        int  b0, b1, b2;
        int  model_acc = 0, model_rej = 0, acc_beats = 0, need_beats = -1;
        int  out_beats = 0, cyc = 0;
        bit  saw_valid = 0, fin = 0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_rise",  64'(busy),   64'd1);
        check("ready_rise", 64'(iready), 64'd1);
        beat = make_beat(mode);
        while (!fin) begin
            if (cvalid) saw_valid = 1;
            ivalid = (max_beats < 0 || acc_beats < max_beats) &&
                     (mode != 1 || $urandom_range(99) < 75);
            cready = (cyc >= stall) && ($urandom_range(99) < rdy_pct);
            start  = (cyc == restart_cyc);
            ibytes = beat;
            if (stall > 0 && cyc == stall) begin
                check("stall_ready",  64'(iready), 64'd0);
                check("stall_valid",  64'(cvalid), 64'd1);
                check("stall_coeffs", 64'(coeffs), 64'd0);
            end
            if (ivalid && iready) begin
                for (int j = 0; j < IN_BYTES / 3; j++) begin
                    b0 = int'(beat[24*j +: 8]);
                    b1 = int'(beat[24*j+8 +: 8]);
                    b2 = int'(beat[24*j+16 +: 8]);
                    dd[0] = b0 + 256 * (b1 % 16);
                    dd[1] = b1 / 16 + 16 * b2;
                    for (int h = 0; h < 2; h++) begin
                        if (model_acc < N) begin
                            if (dd[h] < QM) begin
                                exp_q.push_back(dd[h]);
                                model_acc++;
                                if (model_acc == N) need_beats = acc_beats + 1;
                            end else begin
                                model_rej++;
                            end
                        end
                    end
                end
                acc_beats++;
                beat = make_beat(mode);
            end
            if (cready && cvalid) begin
                check("extra_beat", 64'(out_beats < N / LANES), 64'd1);
                expv = '0;
                for (int l = 0; l < LANES; l++)
                    if (exp_q.size() > 0) expv[12*l +: 12] = 12'(exp_q.pop_front());
                check($sformatf("coeff_beat%0d", out_beats), 64'(coeffs), 64'(expv));
                out_beats++;
            end
            @(negedge clk);
            cyc++;
            if (done) begin
                fin = 1;
                check("done_beats", 64'(out_beats),  64'(N / LANES));
                check("in_beats",   64'(acc_beats),  64'(need_beats));
                check("busy_fall",  64'(busy),       64'd0);
                check("done_ready", 64'(iready),     64'd0);
`ifdef PARSE_REJCNT_EN
                check("rej_cnt",    64'(rej_cnt),    64'(model_rej));
`endif
                ivalid = 1'b0; cready = 1'b0; start = 1'b0;
                @(negedge clk);
                check("done_pulse", 64'(done), 64'd0);
            end else if (cyc == abort_cyc) begin
                fin = 1;
                if (mode == 2) check("ff_no_valid", 64'(saw_valid | cvalid), 64'd0);
`ifdef PARSE_REJCNT_EN
                check("abort_rej_cnt", 64'(rej_cnt), 64'(model_rej));
`endif
                ivalid = 1'b0; cready = 1'b0; start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("abort");
                rst = 1'b0;
            end else if (cyc >= 4000) begin
                fin = 1;
                check("timeout", 64'd1, 64'd0);
            end
        end
        ivalid = 1'b0; cready = 1'b0; start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        run_poly(0, 100, 0, -1, -1, -1);   // all-zero bytes, output always ready
        run_poly(2, 100, 0,  4, 10, -1);   // all 0xFF: everything rejected
        run_poly(3, 100, 0, -1, -1, -1);   // 00 1D D0: 3328 accepted, 3329 rejected
        run_poly(0, 100, 8, -1, -1, -1);   // output stalled until buffer full
        run_poly(1,  70, 0, -1, -1, 30);   // random bytes, stray i_start mid-run
        run_poly(1,  50, 0, -1, -1, -1);   // random bytes, heavy backpressure
        run_poly(1,  80, 0, -1, 20, -1);   // reset mid-polynomial
        run_poly(1,  60, 0, -1, -1, -1);   // fresh polynomial after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parse_stream.md
# parse_stream

Streaming, parametrised Kyber Parse (rejection sampler). Consumes a SHAKE-128/XOF byte stream under ready/valid flow control and splits every 3 bytes into two 12-bit candidates. It keeps candidates below Q, in order, and emits exactly N_COEFFS coefficients as OUT_LANES-wide beats. It sits between the XOF/Keccak output stage and the NTT-domain matrix-A storage. Compared with the fixed 64-bit, 4-lane parser, it adds a candidate buffer, backpressure on both sides, end-of-polynomial truncation and a done pulse.

## Interface
- IN_BYTES, 24: bytes per input beat; multiple of 3, range 3..48
- OUT_LANES, 4: coefficients per output beat; power of two dividing N_COEFFS
- BUF_DEPTH, 32: candidate buffer entries; must be >= 2*IN_BYTES/3 + OUT_LANES (elaboration error otherwise)
- N_COEFFS, 256: coefficients per polynomial
- Q, 3329: modulus; accept when candidate < Q
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; synchronous and active-high
- i_start  in  1  begin a new polynomial; honoured only in S_IDLE
- i_ibytes  in  IN_BYTES*8  byte k at bits [8k+7:8k]; byte 0 is first in stream
- i_ibytes_valid  in  1  input beat valid
- o_ibytes_ready  out  1  input beat accepted when valid && ready
- o_coeffs  out  OUT_LANES*12  lane 0 at [11:0] is the earliest coefficient
- o_coeffs_valid  out  1  output beat valid
- i_coeffs_ready  in  1  output beat consumed when valid && ready
- o_done  out  1  one-cycle pulse after the last coefficient beat is consumed
- o_busy  out  1  high in S_FILL

## Operation
- Candidate extraction, triplet j = bytes b0, b1, b2 at 3j..3j+2:
  - d1 = b0 + 256*(b1 & 0xF)
  - d2 = (b1 >> 4) + 16*b2
  - All values are 12-bit unsigned.
  - Candidate order within a beat is d1(0), d2(0), d1(1), and so on.
- Accepted candidates (< Q) from one input beat are compacted in order and written to the buffer in the same edge that accepts the beat.
- cnt_acc (0..N_COEFFS) counts candidates written to the buffer. Candidates that would make cnt_acc exceed N_COEFFS are dropped. They are not counted as rejected.
- The buffer pops OUT_LANES entries per consumed output beat. cnt_out counts emitted coefficients.
- State machine:
  - S_IDLE → S_FILL on i_start. cnt_acc, cnt_out and the buffer are cleared at entry.
  - S_FILL → S_DONE when the output beat that brings cnt_out to N_COEFFS is consumed.
  - S_DONE → S_IDLE unconditionally. o_done = 1 only in S_DONE.
- o_ibytes_ready = (S_FILL) && (cnt_acc < N_COEFFS) && (free entries >= 2*IN_BYTES/3). It is computed from registered occupancy only; a same-cycle pop does not raise ready.
- o_coeffs_valid = (S_FILL) && (occupancy >= OUT_LANES).
- Simultaneous push and pop in one cycle is supported; occupancy updates by push − pop.
- i_start outside S_IDLE is ignored. Input beats in S_IDLE or S_DONE are not accepted (ready = 0).
- i_rst in any state returns to S_IDLE and clears the buffer, all counters and all outputs.

## Timing
- Reset values: o_ibytes_ready = 0, o_coeffs = 0, o_coeffs_valid = 0, o_done = 0, o_busy = 0.
- o_busy and o_ibytes_ready rise the cycle after i_start is sampled.
- Latency: an input beat accepted at edge t whose write lifts occupancy to >= OUT_LANES gives o_coeffs_valid = 1 in the cycle after t.
- o_coeffs is stable while o_coeffs_valid = 1 and i_coeffs_ready = 0.
- Throughput: one input beat per cycle while the output drains at least as fast as input arrives.
- o_done asserts the cycle after the final output handshake. o_busy falls in that same cycle.

## Configuration
- PARSE_REJCNT_EN defined:
  - Adds port o_rej_cnt (out, 16) counting candidates >= Q in accepted beats, excluding dropped excess.
  - Saturates at 0xFFFF. Cleared on reset and at S_IDLE → S_FILL. Holds its value after done.
- PARSE_REJCNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- All-zero bytes, IN_BYTES=24, OUT_LANES=4, i_coeffs_ready = 1 → 16 beats accepted, then ready = 0. 64 output beats of zeros, o_done after the 64th, o_rej_cnt = 0.
- All-0xFF bytes for 4 beats → every candidate is 4095 and rejected. o_coeffs_valid stays 0; o_rej_cnt = 64.
- Beat of repeated triplet 00 1D D0 → per triplet d1 = 3328 accepted and d2 = 3329 rejected. Output lanes all 3328; rejects counted.
- Hold i_coeffs_ready = 0 with zero bytes → occupancy reaches 32, o_ibytes_ready drops. o_coeffs holds {0,0,0,0}; on release, the stream resumes with no loss or duplication (compare against a golden model).
- Random bytes compared to a software Parse model → exactly 256 coefficients, in order. Excess candidates in the last beat are dropped; a second i_start mid-run is ignored.
- i_rst asserted mid-polynomial → all outputs at reset values next cycle. A fresh i_start then produces a full correct polynomial.
